// File: rtl/array_op_engine.sv
// array_op_engine: buffered compute array. Input words are transformed by an
//   op chosen from a free-running phase counter, written into a DEPTH-entry
//   circular array and streamed back out; a side port gives random reads.
// Latency: accept at edge N -> array write at N+1 -> out/out_valid after N+2.
//   Random read data is registered, 1 cycle.
// Backpressure: in_ready = !flush. There is no output stall; out_valid is a
//   one-cycle pulse per accepted word.
// Ports:
//   clk, reset (async active-low), flush (sync clear of all state)
//   in_valid/in_ready/in      : input word handshake
//   out_valid/out/out_addr    : result stream and the entry it was written to
//   rd_en/rd_addr/rd_data     : random read port, rd_data holds when rd_en = 0
module array_op_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out,
  output logic [$clog2(DEPTH)-1:0] out_addr,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int AW = $clog2(DEPTH);

  // Phase boundaries: H = 2^(CNT_W-1), H+Q = 2^(CNT_W-1) + 2^(CNT_W-2).
  localparam logic [CNT_W-1:0] CNT_H  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_HQ = {2'b11, {(CNT_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] FIVE  = DATA_W'(5);

  typedef enum logic [2:0] {
    OP_MOD5 = 3'd0,
    OP_HALF = 3'd1,
    OP_SQR  = 3'd2,
    OP_QTR  = 3'd3,
    OP_ZERO = 3'd4
  } op_t;

  logic              accept;
  logic [AW-1:0]     wptr;
  logic [CNT_W-1:0]  cnt;
  op_t               op_sel;

  logic [DATA_W-1:0] temp;
  logic [AW-1:0]     s1_addr;
  op_t               s1_op;
  logic              s1_valid;
  logic [DATA_W-1:0] result;

  logic [AW-1:0]     s2_addr;
  logic              s2_valid;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_ready = !flush;
  assign accept   = in_valid && in_ready;

  // Op is picked from the counter value before it increments.
  always_comb begin
    op_sel = OP_ZERO;
    if (cnt == '0) begin
      op_sel = OP_MOD5;
    end else if (cnt < CNT_H) begin
      op_sel = OP_HALF;
    end else if (cnt == CNT_H) begin
      op_sel = OP_SQR;
    end else if (cnt < CNT_HQ) begin
      op_sel = OP_QTR;
    end
  end

  // Stage-1 transform. The square is evaluated at DATA_W bits so only the
  // low half of the full product survives.
  always_comb begin
    result = '0;
    case (s1_op)
      OP_MOD5: result = temp % FIVE;
      OP_HALF: result = temp >> 1;
      OP_SQR:  result = temp * temp;
      OP_QTR:  result = temp >> 2;
      default: result = '0;
    endcase
  end

  // Stage 0 (capture), stage-1 bookkeeping and stage 2 (output register).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      cnt       <= '0;
      temp      <= '0;
      s1_addr   <= '0;
      s1_op     <= OP_MOD5;
      s1_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_valid  <= 1'b0;
      out       <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      cnt       <= '0;
      temp      <= '0;
      s1_addr   <= '0;
      s1_op     <= OP_MOD5;
      s1_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_valid  <= 1'b0;
      out       <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        temp    <= in;
        s1_addr <= wptr;
        s1_op   <= op_sel;
        wptr    <= wptr + AW'(1);
        cnt     <= cnt + CNT_W'(1);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
      end

      // The array entry was written on the previous edge, so this read
      // returns the fresh result rather than stale contents.
      out       <= mem[s2_addr];
      out_addr  <= s2_addr;
      out_valid <= s2_valid;
    end
  end

  // Result array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (s1_valid) begin
      mem[s1_addr] <= result;
    end
  end

  // Random read: a same-edge stage-1 write to rd_addr is not forwarded,
  // so the old contents are returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (flush) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_array_op_engine.sv
// Directed bench for array_op_engine (DATA_W=32, DEPTH=4, CNT_W=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_array_op_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic        out_valid;
  logic [31:0] out;
  logic [1:0]  out_addr;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  array_op_engine #(.DATA_W(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out       (out),
    .out_addr  (out_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Apply one cycle of inputs, then advance to 1 ns past the next rising edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic re,
                       input logic [1:0] ra, input logic fl);
    in_valid = v; din = d; rd_en = re; rd_addr = ra; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out !== 32'd0) begin tests_failed++; $display("FAIL reset_out: got %0h want 0", out); end
    tests_run++; if (out_addr !== 2'd0) begin tests_failed++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    tests_run++; if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    flush = 1'b1; #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // cnt=0 -> MOD5: 17 % 5 = 2 at entry 0, pulse exactly two edges later.
  task automatic test_first_word();
    drive(1, 32'd17, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early0: got %b want 0", out_valid); end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early1: got %b want 0", out_valid); end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid: got %b want 1", out_valid); end
    tests_run++; if (out !== 32'd2) begin tests_failed++; $display("FAIL first_out: got %0d want 2", out); end
    tests_run++; if (out_addr !== 2'd0) begin tests_failed++; $display("FAIL first_addr: got %0d want 0", out_addr); end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL first_single_pulse: got %b want 0", out_valid); end
  endtask

  // cnt=1 (HALF, entry 1), long idle gap, then cnt=2 must land on entry 2.
  task automatic test_idle_hold();
    drive(1, 32'd100, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd50 || out_addr !== 2'd1) begin
      tests_failed++; $display("FAIL hold_pre: got v=%b out=%0d addr=%0d want v=1 out=50 addr=1", out_valid, out, out_addr); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'd0, 0, 2'd0, 0);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_idle%0d: got %b want 0", i, out_valid); end
    end
    drive(1, 32'd100, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd50 || out_addr !== 2'd2) begin
      tests_failed++; $display("FAIL hold_post: got v=%b out=%0d addr=%0d want v=1 out=50 addr=2", out_valid, out, out_addr); end
  endtask

  // Back-to-back accepts for cnt 3..255 then cnt wraps to 0; every pulse
  // checked in order. Expected values per counter region:
  //   1..127 in=100 -> 50; 128 in=7 -> 49; 129..191 in=100 -> 25;
  //   192 in=5 -> 0; 193..255 in=9 -> 0; 0 in=13 -> 3.
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [1:0]  addr_q[$];
    logic [31:0] d, e;
    logic [1:0]  a;
    int k;
    for (int c = 3; c <= 258; c++) begin
      if (c <= 256) begin
        k = c % 256;
        if (k == 0)        begin d = 32'd13;  e = 32'd3;  end
        else if (k < 128)  begin d = 32'd100; e = 32'd50; end
        else if (k == 128) begin d = 32'd7;   e = 32'd49; end
        else if (k < 192)  begin d = 32'd100; e = 32'd25; end
        else if (k == 192) begin d = 32'd5;   e = 32'd0;  end
        else               begin d = 32'd9;   e = 32'd0;  end
        exp_q.push_back(e);
        addr_q.push_back(k[1:0]);
        drive(1, d, 0, 2'd0, 0);
      end else begin
        drive(0, 32'd0, 0, 2'd0, 0);
      end
      if (c >= 5) begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out !== e || out_addr !== a) begin
          tests_failed++; $display("FAIL stream_cnt%0d: got v=%b out=%0d addr=%0d want v=1 out=%0d addr=%0d",
                                   (c - 2) % 256, out_valid, out, out_addr, e, a); end
      end else begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_fill%0d: got %b want 0", c, out_valid); end
      end
    end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  // Entry 1 holds 0 (cnt 253, ZERO); read it on the edge that writes 50.
  task automatic test_rd_collision();
    drive(1, 32'd100, 0, 2'd0, 0);
    drive(0, 32'd0, 1, 2'd1, 0);
    tests_run++; if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL rd_old: got %0d want 0", rd_data); end
    drive(0, 32'd0, 1, 2'd1, 0);
    tests_run++; if (rd_data !== 32'd50) begin tests_failed++; $display("FAIL rd_new: got %0d want 50", rd_data); end
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd50 || out_addr !== 2'd1) begin
      tests_failed++; $display("FAIL rd_out: got v=%b out=%0d addr=%0d want v=1 out=50 addr=1", out_valid, out, out_addr); end
    drive(0, 32'd0, 0, 2'd3, 0);
    tests_run++; if (rd_data !== 32'd50) begin tests_failed++; $display("FAIL rd_hold: got %0d want 50", rd_data); end
    drive(0, 32'd0, 1, 2'd0, 0);
    tests_run++; if (rd_data !== 32'd3) begin tests_failed++; $display("FAIL rd_entry0: got %0d want 3", rd_data); end
  endtask

  // Flush one cycle after an accept, with in_valid and rd_en also high.
  task automatic test_flush();
    drive(1, 32'd100, 0, 2'd0, 0);
    in_valid = 1'b1; din = 32'd77; rd_en = 1'b1; rd_addr = 2'd0; flush = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL flush_rd_data: got %0d want 0", rd_data); end
    tests_run++; if (out_valid !== 1'b0 || out !== 32'd0) begin
      tests_failed++; $display("FAIL flush_out: got v=%b out=%0d want v=0 out=0", out_valid, out); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 0, 2'd0, 0);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_pulse%0d: got %b want 0", i, out_valid); end
    end
    for (int a = 0; a < 4; a++) begin
      drive(0, 32'd0, 1, 2'(a), 0);
      tests_run++; if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL flush_entry%0d: got %0d want 0", a, rd_data); end
    end
    drive(1, 32'd17, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd2 || out_addr !== 2'd0) begin
      tests_failed++; $display("FAIL flush_restart: got v=%b out=%0d addr=%0d want v=1 out=2 addr=0", out_valid, out, out_addr); end
  endtask

  // Walk cnt from 1 up to 128 and square 0x00010001: full product is
  // 0x1_0002_0001, low 32 bits 0x00020001, entry (1+127)%4 = 0.
  task automatic test_sqr_wrap();
    for (int i = 0; i < 127; i++) begin
      drive(1, 32'd0, 0, 2'd0, 0);
    end
    drive(1, 32'h0001_0001, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'h0002_0001 || out_addr !== 2'd0) begin
      tests_failed++; $display("FAIL sqr: got v=%b out=%0h addr=%0d want v=1 out=20001 addr=0", out_valid, out, out_addr); end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sqr_single: got %b want 0", out_valid); end
  endtask

  // Reset dropped between edges with words in flight; then a word accepted
  // on the very first edge after release.
  task automatic test_async_reset();
    drive(0, 32'd0, 1, 2'd0, 0);
    tests_run++; if (rd_data !== 32'h0002_0001) begin tests_failed++; $display("FAIL ar_rd_pre: got %0h want 20001", rd_data); end
    drive(1, 32'd100, 0, 2'd0, 0);
    drive(1, 32'd100, 0, 2'd0, 0);
    drive(1, 32'd100, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd25 || out_addr !== 2'd1) begin
      tests_failed++; $display("FAIL ar_pre: got v=%b out=%0d addr=%0d want v=1 out=25 addr=1", out_valid, out, out_addr); end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || out !== 32'd0 || out_addr !== 2'd0 || rd_data !== 32'd0) begin
      tests_failed++; $display("FAIL ar_immediate: got v=%b out=%0d addr=%0d rd=%0h want all 0", out_valid, out, out_addr, rd_data); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'd0, 0, 2'd0, 0);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ar_no_pulse%0d: got %b want 0", i, out_valid); end
    end
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; din = 32'd17;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ar_release_early: got %b want 0", out_valid); end
    drive(0, 32'd0, 0, 2'd0, 0);
    tests_run++; if (out_valid !== 1'b1 || out !== 32'd2 || out_addr !== 2'd0) begin
      tests_failed++; $display("FAIL ar_release_accept: got v=%b out=%0d addr=%0d want v=1 out=2 addr=0", out_valid, out, out_addr); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_idle_hold();
    test_back_to_back();
    test_rd_collision();
    test_flush();
    test_sqr_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
